// File: rtl/async_pipeline_receiver.sv
// async_pipeline_receiver: 4-phase handshake sink from an async pipeline into a clocked FIFO.
// req_in is synchronized; one word is written per request phase, stalling (no ack) while full.
module async_pipeline_receiver #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_in,
   input  logic [3:0] data_in,
   output logic       ack_out,
   output logic [3:0] dout,
   output logic       dout_valid,
   input  logic       dout_ready,
   output logic [3:0] fifo_count,
   output logic [7:0] word_count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [3:0] FULL = 4'(DEPTH);
   typedef enum logic {IDLE, WAIT_LOW} state_t;
   state_t state;
   logic s1, s2, req_s, wr, rd;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [3:0] mem [DEPTH];
   assign req_s      = s2;
   // full is judged on the registered count, so a pop only frees space for the next cycle
   assign wr         = state == IDLE && req_s && fifo_count < FULL;
   assign rd         = dout_valid && dout_ready;
   assign dout_valid = fifo_count != 4'd0;
   assign dout       = dout_valid ? mem[rd_ptr] : 4'd0;
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= req_in;
         s2 <= s1;
      end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state   <= IDLE;
         ack_out <= 1'b0;
      end else if (state == IDLE) begin
         if (wr) begin
            state   <= WAIT_LOW;
            ack_out <= 1'b1;
         end
      end else if (!req_s) begin
         state   <= IDLE;
         ack_out <= 1'b0;
      end
   always_ff @(posedge clk)
      if (wr) mem[wr_ptr] <= data_in;
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= 4'd0;
         word_count <= 8'd0;
      end else begin
         wr_ptr     <= wr ? wr_ptr + AW'(1) : wr_ptr;
         rd_ptr     <= rd ? rd_ptr + AW'(1) : rd_ptr;
         fifo_count <= fifo_count + {3'd0, wr} - {3'd0, rd};
         word_count <= word_count + {7'd0, wr};
      end
endmodule

// File: tb/tb_async_pipeline_receiver.sv
// tb_async_pipeline_receiver: directed and randomized handshakes against a queue-based model.
module tb_async_pipeline_receiver;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic req_in = 1'b0;
  logic [3:0] data_in = 4'd0;
  logic ack_out;
  logic [3:0] dout;
  logic dout_valid;
  logic dout_ready = 1'b0;
  logic [3:0] fifo_count;
  logic [7:0] word_count;
  int vectors = 0;
  int miscompares = 0;
  bit mon_en = 1'b0;
  int maxc = 0;
  logic [3:0] sent[$];
  logic [3:0] got[$];
  async_pipeline_receiver #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .req_in(req_in), .data_in(data_in), .ack_out(ack_out),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .fifo_count(fifo_count), .word_count(word_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk)
    if (mon_en && reset && dout_valid && dout_ready) got.push_back(dout);
  always @(negedge clk)
    if (mon_en && int'(fifo_count) > maxc) maxc = int'(fifo_count);
  task automatic chk(input string tag, input bit ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $error("FAIL %s", tag);
    end
  endtask
  task automatic do_reset();
    reset = 1'b0;
    req_in = 1'b0;
    dout_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask
  task automatic wait_ack(input logic v, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ack_out === v) begin
        ok = 1'b1;
        break;
      end
    end
  endtask
  task automatic hs(input logic [3:0] d);
    bit ok;
    data_in = d;
    req_in = 1'b1;
    wait_ack(1'b1, ok);
    chk("hs_ack_rise", ok === 1'b1);
    sent.push_back(d);
    req_in = 1'b0;
    wait_ack(1'b0, ok);
    chk("hs_ack_fall", ok === 1'b1);
  endtask
  task automatic pop(input logic [3:0] exp);
    chk("pop_valid", dout_valid === 1'b1);
    chk("pop_dout", dout === exp);
    dout_ready = 1'b1;
    @(negedge clk);
    dout_ready = 1'b0;
  endtask
  initial begin
    bit ok;
    logic [3:0] d;
    repeat (2) @(negedge clk);
    chk("rst_ack", ack_out === 1'b0);
    chk("rst_valid", dout_valid === 1'b0);
    chk("rst_count", fifo_count === 4'd0);
    chk("rst_wc", word_count === 8'd0);
    chk("rst_dout", dout === 4'd0);
    reset = 1'b1;
    data_in = 4'hA;
    req_in = 1'b1;
    repeat (2) @(negedge clk);
    chk("lat_ack_e2", ack_out === 1'b0);
    chk("lat_valid_e2", dout_valid === 1'b0);
    @(negedge clk);
    chk("lat_ack_e3", ack_out === 1'b1);
    chk("lat_dout", dout === 4'hA);
    chk("lat_valid", dout_valid === 1'b1);
    chk("lat_count", fifo_count === 4'd1);
    chk("lat_wc", word_count === 8'd1);
    req_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("rtz_ack_e2", ack_out === 1'b1);
    @(negedge clk);
    chk("rtz_ack_e3", ack_out === 1'b0);
    pop(4'hA);
    chk("pop_empty", dout_valid === 1'b0);
    dout_ready = 1'b1;
    @(negedge clk);
    dout_ready = 1'b0;
    chk("pop_while_empty", fifo_count === 4'd0);
    do_reset();
    for (int i = 1; i <= 4; i++) hs(4'(i));
    data_in = 4'd5;
    req_in = 1'b1;
    repeat (8) @(negedge clk);
    chk("full_stall_ack", ack_out === 1'b0);
    chk("full_count", fifo_count === 4'd4);
    chk("full_wc", word_count === 8'd4);
    pop(4'd1);
    chk("full_no_same_cycle_write", fifo_count === 4'd3);
    wait_ack(1'b1, ok);
    chk("full_fifth_acked", ok === 1'b1);
    chk("full_count_after", fifo_count === 4'd4);
    req_in = 1'b0;
    wait_ack(1'b0, ok);
    chk("full_fifth_fall", ok === 1'b1);
    for (int i = 2; i <= 5; i++) pop(4'(i));
    chk("full_drained", dout_valid === 1'b0);
    do_reset();
    data_in = 4'd7;
    req_in = 1'b1;
    repeat (20) @(negedge clk);
    chk("hold_wc", word_count === 8'd1);
    chk("hold_count", fifo_count === 4'd1);
    chk("hold_ack", ack_out === 1'b1);
    req_in = 1'b0;
    wait_ack(1'b0, ok);
    chk("hold_fall", ok === 1'b1);
    do_reset();
    hs(4'd1);
    hs(4'd2);
    data_in = 4'd3;
    req_in = 1'b1;
    wait_ack(1'b1, ok);
    chk("mid_ack", ok === 1'b1);
    chk("mid_count3", fifo_count === 4'd3);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_ack", ack_out === 1'b0);
    chk("mid_rst_count", fifo_count === 4'd0);
    chk("mid_rst_valid", dout_valid === 1'b0);
    chk("mid_rst_wc", word_count === 8'd0);
    chk("mid_rst_dout", dout === 4'd0);
    @(negedge clk);
    data_in = 4'd9;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rel_ack_e2", ack_out === 1'b0);
    @(negedge clk);
    chk("rel_ack_e3", ack_out === 1'b1);
    chk("rel_dout", dout === 4'd9);
    repeat (10) @(negedge clk);
    chk("rel_once", word_count === 8'd1);
    req_in = 1'b0;
    do_reset();
    sent.delete();
    got.delete();
    maxc = 0;
    mon_en = 1'b1;
    dout_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      d = 4'($urandom_range(0, 15));
      hs(d);
    end
    repeat (4) @(negedge clk);
    mon_en = 1'b0;
    dout_ready = 1'b0;
    chk("wrap_wc", word_count === 8'd0);
    chk("wrap_empty", fifo_count === 4'd0);
    chk("conc_maxcount", maxc <= 1);
    chk("wrap_delivered", got.size() == 256);
    for (int i = 0; i < 256 && i < got.size(); i++) chk("order", got[i] === sent[i]);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
